// File: rtl/mips_defs_pkg.sv
// Shared MIPS definitions: load/store opcodes, exception codes, M-stage FSM states
// and a small decoder turning an opcode into load/store kind and access size.
package mips_defs_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        EXC_NONE = 2'b00,
        EXC_ADEL = 2'b01,
        EXC_ADES = 2'b10,
        EXC_BUS  = 2'b11
    } exc_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef struct packed {
        logic  isLoad;
        logic  isStore;
        size_e size;
    } memop_t;

    function automatic memop_t decodeMemOp(input logic [5:0] op);
        memop_t m;
        m.isLoad  = 1'b0;
        m.isStore = 1'b0;
        m.size    = SZ_WORD;
        case (op)
            OP_LB, OP_LBU: begin m.isLoad  = 1'b1; m.size = SZ_BYTE; end
            OP_LH, OP_LHU: begin m.isLoad  = 1'b1; m.size = SZ_HALF; end
            OP_LW:         begin m.isLoad  = 1'b1; m.size = SZ_WORD; end
            OP_SB:         begin m.isStore = 1'b1; m.size = SZ_BYTE; end
            OP_SH:         begin m.isStore = 1'b1; m.size = SZ_HALF; end
            OP_SW:         begin m.isStore = 1'b1; m.size = SZ_WORD; end
            default:       ;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_ext.sv
// Load data extractor: picks the addressed byte/half out of a read word and
// sign- or zero-extends it according to the load opcode; non-loads yield zero.
module load_ext
    import mips_defs_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  a_i,
    input  logic [5:0]  opcode_i,
    output logic [31:0] ext_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel = rdata_i[7:0];
        case (a_i)
            2'd0: byteSel = rdata_i[7:0];
            2'd1: byteSel = rdata_i[15:8];
            2'd2: byteSel = rdata_i[23:16];
            2'd3: byteSel = rdata_i[31:24];
            default: ;
        endcase
        halfSel = a_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        ext_o = 32'd0;
        case (opcode_i)
            OP_LB:  ext_o = {{24{byteSel[7]}}, byteSel};
            OP_LBU: ext_o = {24'd0, byteSel};
            OP_LH:  ext_o = {{16{halfSel[15]}}, halfSel};
            OP_LHU: ext_o = {16'd0, halfSel};
            OP_LW:  ext_o = rdata_i;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS M-stage: issues loads/stores on a req/ready data bus, stalls upstream while
// an access is outstanding, flags misalignment and bus timeouts, and registers M/W.
module mem_access_stage
    import mips_defs_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_M_in,
    input  logic [31:0] ALUout_M,
    input  logic [31:0] RT_M_in,
    input  logic [4:0]  A3_M_in,
    input  logic [31:0] PC8_M_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        stall_M,
    output logic [31:0] Instr_W_in,
    output logic [31:0] ALUout_W,
    output logic [31:0] MemData_W,
    output logic [4:0]  A3_W_in,
    output logic [31:0] PC8_W_in,
    output logic [1:0]  exc_W
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      instrW_q, instrW_d;
    logic [31:0]      aluW_q, aluW_d;
    logic [31:0]      memDataW_q, memDataW_d;
    logic [4:0]       a3W_q, a3W_d;
    logic [31:0]      pc8W_q, pc8W_d;
    exc_e             excW_q, excW_d;

    memop_t      memOp;
    logic        isMem;
    logic        aligned;
    logic        timeoutFire;
    logic [1:0]  byteAddr;
    logic [31:0] loadExt;

    assign memOp    = decodeMemOp(Instr_M_in[31:26]);
    assign isMem    = memOp.isLoad | memOp.isStore;
    assign byteAddr = ALUout_M[1:0];

    always_comb begin
        aligned = 1'b1;
        case (memOp.size)
            SZ_HALF: aligned = ~byteAddr[0];
            SZ_WORD: aligned = (byteAddr == 2'b00);
            default: ;
        endcase
    end

    // Gating with reset makes the request drop the instant reset asserts.
    assign mem_req = reset & (((state_q == ST_IDLE) & isMem & aligned) | (state_q == ST_WAIT));
    assign mem_we   = memOp.isStore;
    assign mem_addr = {ALUout_M[31:2], 2'b00};

    assign timeoutFire = (state_q == ST_WAIT) & ~mem_ready & (cnt_q == CNT_W'(TIMEOUT - 1));
    assign stall_M     = mem_req & ~mem_ready & ~timeoutFire;

    always_comb begin
        mem_be    = 4'b0000;
        mem_wdata = 32'd0;
        if (isMem) begin
            case (memOp.size)
                SZ_BYTE: mem_be = 4'b0001 << byteAddr;
                SZ_HALF: mem_be = byteAddr[1] ? 4'b1100 : 4'b0011;
                default: mem_be = 4'b1111;
            endcase
        end
        if (memOp.isStore) begin
            case (memOp.size)
                SZ_BYTE: mem_wdata = {4{RT_M_in[7:0]}};
                SZ_HALF: mem_wdata = {2{RT_M_in[15:0]}};
                default: mem_wdata = RT_M_in;
            endcase
        end
    end

    load_ext u_load_ext (
        .rdata_i  (mem_rdata),
        .a_i      (byteAddr),
        .opcode_i (Instr_M_in[31:26]),
        .ext_o    (loadExt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_req && !mem_ready) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (mem_ready || timeoutFire) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Faulting instructions still retire, but with no writeback and no load data.
    always_comb begin
        instrW_d   = 32'd0;
        aluW_d     = 32'd0;
        memDataW_d = 32'd0;
        a3W_d      = 5'd0;
        pc8W_d     = 32'd0;
        excW_d     = EXC_NONE;
        if (!stall_M) begin
            instrW_d   = Instr_M_in;
            aluW_d     = ALUout_M;
            pc8W_d     = PC8_M_in;
            a3W_d      = A3_M_in;
            memDataW_d = memOp.isLoad ? loadExt : 32'd0;
            if (isMem && !aligned) begin
                a3W_d      = 5'd0;
                memDataW_d = 32'd0;
                excW_d     = memOp.isLoad ? EXC_ADEL : EXC_ADES;
            end else if (timeoutFire) begin
                a3W_d      = 5'd0;
                memDataW_d = 32'd0;
                excW_d     = EXC_BUS;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            instrW_q   <= 32'd0;
            aluW_q     <= 32'd0;
            memDataW_q <= 32'd0;
            a3W_q      <= 5'd0;
            pc8W_q     <= 32'd0;
            excW_q     <= EXC_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            instrW_q   <= instrW_d;
            aluW_q     <= aluW_d;
            memDataW_q <= memDataW_d;
            a3W_q      <= a3W_d;
            pc8W_q     <= pc8W_d;
            excW_q     <= excW_d;
        end
    end

    assign Instr_W_in = instrW_q;
    assign ALUout_W   = aluW_q;
    assign MemData_W  = memDataW_q;
    assign A3_W_in    = a3W_q;
    assign PC8_W_in   = pc8W_q;
    assign exc_W      = excW_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases plus random instruction streams,
// each instruction checked cycle by cycle against a transaction-level model.
module tb_mem_access_stage;

    localparam int TIMEOUT = 16;
    localparam int NEVER   = 99;

    localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
    localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B, ADD = 6'h00, LUI = 6'h0F;

    logic        clk = 1'b0;
    logic        rstN;
    logic [31:0] Instr_M_in, ALUout_M, RT_M_in, PC8_M_in, mem_rdata;
    logic [4:0]  A3_M_in;
    logic        mem_ready;
    logic        mem_req, mem_we, stall_M;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] Instr_W_in, ALUout_W, MemData_W, PC8_W_in;
    logic [4:0]  A3_W_in;
    logic [1:0]  exc_W;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .reset(rstN),
        .Instr_M_in(Instr_M_in), .ALUout_M(ALUout_M), .RT_M_in(RT_M_in),
        .A3_M_in(A3_M_in), .PC8_M_in(PC8_M_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .stall_M(stall_M), .Instr_W_in(Instr_W_in), .ALUout_W(ALUout_W),
        .MemData_W(MemData_W), .A3_W_in(A3_W_in), .PC8_W_in(PC8_W_in), .exc_W(exc_W)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int opSize(input logic [5:0] op);
        case (op)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, SW:      return 4;
            default:     return 0;
        endcase
    endfunction

    function automatic bit isLoadOp(input logic [5:0] op);
        return (op == LB) || (op == LBU) || (op == LH) || (op == LHU) || (op == LW);
    endfunction

    function automatic logic [31:0] expLoad(input logic [5:0] op, input logic [1:0] a, input logic [31:0] rdata);
        logic [31:0] w;
        w = rdata >> (int'(a) * 8);
        case (op)
            LB:      return 32'($signed(w[7:0]));
            LBU:     return w & 32'h0000_00FF;
            LH:      return 32'($signed(w[15:0]));
            LHU:     return w & 32'h0000_FFFF;
            default: return rdata;
        endcase
    endfunction

    // Runs one instruction from presentation to retirement; lat = wait cycles before ready.
    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                                 input logic [4:0] a3, input logic [31:0] pc8, input int lat,
                                 input logic [31:0] rdata);
        logic [31:0] instr, expWdata, expMd;
        logic [3:0]  expBe;
        logic [1:0]  expExc;
        int sz, kEnd;
        bit ld, mis, req, tmo;
        instr = {op, 26'($urandom)};
        sz    = opSize(op);
        ld    = isLoadOp(op);
        mis   = (sz != 0) && ((addr % sz) != 0);
        req   = (sz != 0) && !mis;
        tmo   = req && (lat > TIMEOUT - 1);
        kEnd  = !req ? 0 : ((lat < TIMEOUT - 1) ? lat : TIMEOUT - 1);
        expBe = (sz == 1) ? (4'b0001 << addr[1:0]) : (sz == 2) ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        expWdata = (sz == 1) ? rt[7:0] * 32'h0101_0101 : (sz == 2) ? rt[15:0] * 32'h0001_0001 : rt;
        Instr_M_in = instr; ALUout_M = addr; RT_M_in = rt; A3_M_in = a3; PC8_M_in = pc8;
        for (int k = 0; k <= kEnd; k++) begin
            mem_ready = req && (k == lat);
            mem_rdata = (k == lat) ? rdata : $urandom();
            @(negedge clk);
            checkOutput("memReq", 32'(mem_req), 32'(req));
            checkOutput("stall", 32'(stall_M), 32'(k < kEnd));
            if (req) begin
                checkOutput("memAddr", mem_addr, {addr[31:2], 2'b00});
                checkOutput("memWe", 32'(mem_we), 32'(!ld));
                if (!ld) begin
                    checkOutput("memBe", 32'(mem_be), 32'(expBe));
                    checkOutput("memWdata", mem_wdata, expWdata);
                end
            end
            @(posedge clk);
            #1;
            if (k < kEnd) begin
                checkOutput("bubbleInstr", Instr_W_in, 32'd0);
                checkOutput("bubbleA3", 32'(A3_W_in), 32'd0);
                checkOutput("bubbleExc", 32'(exc_W), 32'd0);
            end
        end
        expExc = mis ? (ld ? 2'b01 : 2'b10) : (tmo ? 2'b11 : 2'b00);
        expMd  = (ld && expExc == 2'b00) ? expLoad(op, addr[1:0], rdata) : 32'd0;
        checkOutput("retInstr", Instr_W_in, instr);
        checkOutput("retAlu", ALUout_W, addr);
        checkOutput("retPc8", PC8_W_in, pc8);
        checkOutput("retA3", 32'(A3_W_in), (expExc == 2'b00) ? 32'(a3) : 32'd0);
        checkOutput("retExc", 32'(exc_W), 32'(expExc));
        checkOutput("retMemData", MemData_W, expMd);
        mem_ready = 1'b0;
    endtask

    // Presents a never-completing store, lets it wait, then asserts reset asynchronously.
    task automatic resetMidAccess(input int waitEdges);
        Instr_M_in = {SW, 26'd0}; ALUout_M = 32'h0000_0400; RT_M_in = 32'h5555_AAAA;
        A3_M_in = 5'd3; PC8_M_in = 32'h0000_1008; mem_ready = 1'b0;
        for (int i = 0; i < waitEdges; i++) @(posedge clk);
        #2;
        checkOutput("reqBeforeReset", 32'(mem_req), 32'd1);
        rstN = 1'b0;
        #1;
        checkOutput("rstReq", 32'(mem_req), 32'd0);
        checkOutput("rstStall", 32'(stall_M), 32'd0);
        checkOutput("rstInstr", Instr_W_in, 32'd0);
        checkOutput("rstAlu", ALUout_W, 32'd0);
        checkOutput("rstPc8", PC8_W_in, 32'd0);
        checkOutput("rstA3", 32'(A3_W_in), 32'd0);
        checkOutput("rstExc", 32'(exc_W), 32'd0);
        checkOutput("rstMemData", MemData_W, 32'd0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    logic [5:0] opsTab [10] = '{LB, LH, LW, LBU, LHU, SB, SH, SW, ADD, LUI};

    initial begin
        rstN = 1'b0;
        Instr_M_in = {LW, 26'd0}; ALUout_M = 32'd0; RT_M_in = 32'd0; A3_M_in = 5'd1;
        PC8_M_in = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
        #1;
        checkOutput("resetReq", 32'(mem_req), 32'd0);
        checkOutput("resetStall", 32'(stall_M), 32'd0);
        checkOutput("resetInstr", Instr_W_in, 32'd0);
        checkOutput("resetA3", 32'(A3_W_in), 32'd0);
        checkOutput("resetExc", 32'(exc_W), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstN = 1'b1;

        applyStimulus(ADD, 32'd5, 32'h1111_2222, 5'd8, 32'h0000_0048, 0, 32'd0);
        checkOutput("addA3", 32'(A3_W_in), 32'd8);
        checkOutput("addAlu", ALUout_W, 32'd5);
        resetMidAccess(0);

        applyStimulus(LW, 32'h0000_0100, 32'd0, 5'd9, 32'h0000_0010, 0, 32'hDEAD_BEEF);
        checkOutput("lwData", MemData_W, 32'hDEAD_BEEF);
        applyStimulus(LB, 32'h0000_0103, 32'd0, 5'd10, 32'h0000_0014, 0, 32'h80FF_FFFF);
        checkOutput("lbData", MemData_W, 32'hFFFF_FF80);
        applyStimulus(LBU, 32'h0000_0103, 32'd0, 5'd10, 32'h0000_0018, 0, 32'h80FF_FFFF);
        checkOutput("lbuData", MemData_W, 32'h0000_0080);
        applyStimulus(SH, 32'h0000_0202, 32'h1234_ABCD, 5'd0, 32'h0000_001C, 3, 32'd0);
        applyStimulus(LW, 32'h0000_0101, 32'd0, 5'd11, 32'h0000_0020, 0, 32'd0);
        checkOutput("adelExc", 32'(exc_W), 32'd1);
        applyStimulus(SW, 32'h0000_0300, 32'hCAFE_F00D, 5'd0, 32'h0000_0024, NEVER, 32'd0);
        checkOutput("timeoutExc", 32'(exc_W), 32'd3);
        applyStimulus(ADD, 32'd7, 32'd0, 5'd12, 32'h0000_0028, 0, 32'd0);

        resetMidAccess(5);
        applyStimulus(ADD, 32'd9, 32'd0, 5'd13, 32'h0000_002C, 0, 32'd0);
        applyStimulus(SW, 32'h0000_0304, 32'h0BAD_F00D, 5'd0, 32'h0000_0030, NEVER, 32'd0);
        applyStimulus(LHU, 32'h0000_0306, 32'd0, 5'd14, 32'h0000_0034, TIMEOUT - 1, 32'h8765_4321);

        for (int n = 0; n < 80; n++) begin
            applyStimulus(opsTab[$urandom_range(0, 9)], $urandom(), $urandom(),
                          5'($urandom_range(1, 31)), $urandom(),
                          ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 3), $urandom());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
